// File: rtl/aes_stream_pkg.sv
// Shared types for the AES HWPE streamer word/block conversion path.
// Used by block_unstacker and block_unstacker_buf.
package aes_stream_pkg;

    localparam int unsigned WORD_W  = 32;
    localparam int unsigned N_WORDS = 4;
    localparam int unsigned BLOCK_W = WORD_W * N_WORDS;

    localparam logic [1:0] IDX_LAST = 2'(N_WORDS - 1);

    typedef logic [WORD_W-1:0]  word_t;
    typedef logic [BLOCK_W-1:0] block_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } unstack_state_e;

    // Word i of a block, counting from the most significant end.
    function automatic word_t word_sel(block_t b, logic [1:0] i);
        word_sel = b[BLOCK_W-1-WORD_W*int'(i) -: WORD_W];
    endfunction

endpackage

// File: rtl/block_unstacker_buf.sv
// 128-bit holding register with a valid flag (load / take / clear).
// Serves as the prefetch buffer when BLOCK_UNSTACKER_PREFETCH_EN is defined.
module block_unstacker_buf
    import aes_stream_pkg::*;
(
    input  logic   clk_i,
    input  logic   rst_ni,
    input  logic   clr_i,
    input  logic   load_i,
    input  logic   take_i,
    input  block_t data_i,
    output block_t data_o,
    output logic   valid_o
);

    block_t data_q;
    logic   valid_q;

    // Clear dominates; a load wins over a take in the same cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else if (clr_i) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else if (load_i) begin
            data_q  <= data_i;
            valid_q <= 1'b1;
        end else if (take_i) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/block_unstacker.sv
// Splits 128-bit AES result blocks into four 32-bit words, MSW first.
// Optional BLOCK_UNSTACKER_PREFETCH_EN adds a second block buffer.
module block_unstacker
    import aes_stream_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               clr_i,
    input  logic               enable_i,
    input  logic               valid_i,
    output logic               ready_o,
    input  logic [BLOCK_W-1:0] block_i,
    output logic               valid_o,
    input  logic               ready_i,
    output logic [WORD_W-1:0]  word_o,
    output logic [1:0]         idx_o,
    output logic               last_o
);

    unstack_state_e state_q, state_d;
    logic [1:0]     idx_q, idx_d;
    block_t         hold_q, hold_d;

    logic emit;
    logic in_xfer;
    logic out_xfer;
    logic last_xfer;

    assign emit      = (state_q == EMIT);
    assign valid_o   = enable_i & emit;
    assign last_o    = valid_o & (idx_q == IDX_LAST);
    assign out_xfer  = valid_o & ready_i;
    assign last_xfer = out_xfer & (idx_q == IDX_LAST);
    assign in_xfer   = valid_i & ready_o;

`ifdef BLOCK_UNSTACKER_PREFETCH_EN
    block_t pend_data;
    logic   pend_valid;
    logic   pend_load;
    logic   pend_take;

    // Upstream sees a fixed ready while the prefetch slot is free.
    assign ready_o = enable_i & ~pend_valid;

    // A block arriving on the last word with no pending block goes
    // straight into hold, so pend only fills mid-block.
    assign pend_take = last_xfer & pend_valid;
    assign pend_load = in_xfer & emit & ~(last_xfer & ~pend_valid);

    block_unstacker_buf u_pend (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clr_i   (clr_i),
        .load_i  (pend_load),
        .take_i  (pend_take),
        .data_i  (block_i),
        .data_o  (pend_data),
        .valid_o (pend_valid)
    );
`else
    // Next block is accepted only as the last word leaves.
    assign ready_o = enable_i & (~emit | (last_o & ready_i));
`endif

    // Next state for the FSM, word index and hold buffer.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        hold_d  = hold_q;
        if (enable_i) begin
            unique case (state_q)
                IDLE: begin
                    if (in_xfer) begin
                        hold_d  = block_i;
                        idx_d   = '0;
                        state_d = EMIT;
                    end
                end
                EMIT: begin
                    if (out_xfer) begin
                        if (idx_q != IDX_LAST) begin
                            idx_d = idx_q + 2'd1;
                        end else begin
                            idx_d = '0;
`ifdef BLOCK_UNSTACKER_PREFETCH_EN
                            if (pend_valid) begin
                                hold_d = pend_data;
                            end else if (in_xfer) begin
                                hold_d = block_i;
                            end else begin
                                hold_d  = '0;
                                state_d = IDLE;
                            end
`else
                            if (in_xfer) begin
                                hold_d = block_i;
                            end else begin
                                hold_d  = '0;
                                state_d = IDLE;
                            end
`endif
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    idx_d   = '0;
                    hold_d  = '0;
                end
            endcase
        end
    end

    // State registers; clr_i discards any partial block.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            idx_q   <= '0;
            hold_q  <= '0;
        end else if (clr_i) begin
            state_q <= IDLE;
            idx_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            hold_q  <= hold_d;
        end
    end

    assign word_o = word_sel(hold_q, idx_q);
    assign idx_o  = idx_q;

endmodule
